mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Sole owner of the byte-wide RAM/IO port.
- Downstream of load_store_buffer: serves its lsb_load / lsb_store requests and returns finish_load / finish_store.
- Also serves the instruction-fetch unit.
- Serialises each access into 1/2/4 byte beats, assembles read words, and sign- or zero-extends load results.

Parameters:
- IO_BASE, 32'h00030000, addresses >= IO_BASE are memory-mapped IO.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; asynchronous, active-high
- rdy_in  input  1  pause when low
- roll_back  input  1  misprediction flush
- mem_din  input  8  RAM read byte
- mem_dout  output  8  RAM write byte
- mem_a  output  32  RAM byte address
- mem_wr  output  1  1 = write beat
- io_buffer_full  input  1  UART buffer full
- if_req  input  1  fetch request (level, held until if_done)
- if_addr  input  32  fetch address
- if_done  output  1  one-cycle pulse, if_inst valid
- if_inst  output  32  fetched word, little-endian
- lsb_load  input  1  load request (level)
- load_address  input  32  load address
- op_type_load  input  6  load opcode: LB/LH/LW/LBU/LHU
- finish_load  output  1  one-cycle pulse
- data_load  output  32  extended load result
- lsb_store  input  1  store request (level)
- store_address  input  32  store address
- data_store  input  32  store data; low bytes used
- op_type_store  input  6  store opcode: SB/SH/SW
- finish_store  output  1  one-cycle pulse

Behaviour:
- Reset: all outputs 0, state IDLE, beat counter 0. Asynchronous, so reset also clears an access in flight; no done pulse is issued for it.
- States and transitions:
  - IDLE: accept one request with priority STORE > LOAD > FETCH, otherwise stay in IDLE.
  - IDLE -> STORE, LOAD or FETCH on accept.
  - STORE, LOAD, FETCH -> DONE on the final beat.
  - DONE -> IDLE unconditionally.
- DONE lasts exactly one cycle so a requester has time to drop its level request. No request is accepted in DONE, which prevents double service.
- Beat count n: byte ops 1, half ops 2, word ops 4, fetch 4.
- Read timing: the accept edge drives mem_a = addr. Each later edge drives mem_a = addr+k and captures mem_din as byte k-1 of the result. The DONE edge registers the result and pulses done.
- Read latency: done is high n+1 cycles after the accept edge, e.g. LW/fetch = 5, LB = 2.
- Read addresses past the last beat are don't-care, and mem_wr = 0 throughout a read.
- Write timing: the accept edge drives mem_a = addr, mem_dout = data_store[7:0], mem_wr = 1. Edge k drives addr+k with byte k.
- The edge after the last beat sets mem_wr = 0 and pulses finish_store, so the write latency is n cycles.
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
- IO stall: a store with address >= IO_BASE is held in IDLE while io_buffer_full = 1, and it blocks lower-priority requests.
- IO loads issue exactly one beat sequence; no re-reads are allowed (they have side effects).
- roll_back:
  - In FETCH or LOAD: abort to IDLE on the next edge with no done pulse.
  - In IDLE: no request is accepted that cycle.
  - In STORE: ignored, because the store is already committed and must complete.
  - In DONE: the done pulse still occurs, and requesters discard it.
- rdy_in low: all registers freeze; the mem_wr output is gated to 0, i.e. mem_wr = mem_wr_q & rdy_in.
  - A read beat resumes by re-presenting the held address, so the capture stays aligned.
- Addresses wrap modulo 2^32 and no alignment is required.
- Simultaneous if_req, lsb_load and lsb_store: the store is served first, then the load, then the fetch, each through IDLE.

Decomposition:
- Shared package operaType.v: opcode constants LB, LH, LW, LBU, LHU, SB, SH, SW; controller state encodings; TRUE/FALSE.
- No sub-module is needed. The width decode and extension function stays inline as a small combinational always block.

Test Plan:
- if_req, if_addr=0x100, RAM[0x100..0x103]=13 05 00 00 -> if_done 5 cycles after accept with if_inst=0x00000513; mem_wr never 1.
- LB at 0x200 with RAM=0x80 -> data_load=0xFFFFFF80. LBU at the same address -> 0x00000080, finish_load 2 cycles after accept.
- SH, store_address=0x300, data_store=0x1234ABCD -> beats (0x300,CD) and (0x301,AB) with mem_wr=1, then finish_store on the next cycle; RAM[0x302] unchanged.
- lsb_store, lsb_load and if_req raised in the same cycle -> service order store, load, fetch, with one DONE and one IDLE cycle between each; each done fires exactly once.
- roll_back in the 2nd beat of an LW -> no finish_load, back in IDLE next cycle. roll_back during a SW -> all 4 write beats complete and finish_store fires.
- SB to 0x30000 with io_buffer_full=1 for 10 cycles, then 0 -> mem_wr stays 0 and if_req is blocked while full; one write beat follows release. rdy_in low mid-LW stretches the access and the result is still correct.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Opcodes, controller states and widths shared by the byte-serial memory controller.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned CNT_W  = 3;

  localparam logic [ADDR_W-1:0] IO_BASE_DEF = 32'h0003_0000;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t LB  = 6'd1;
  localparam op_t LH  = 6'd2;
  localparam op_t LW  = 6'd3;
  localparam op_t LBU = 6'd4;
  localparam op_t LHU = 6'd5;
  localparam op_t SB  = 6'd6;
  localparam op_t SH  = 6'd7;
  localparam op_t SW  = 6'd8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_STORE = 3'd1,
    ST_LOAD  = 3'd2,
    ST_FETCH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Number of byte beats an access needs; unknown opcodes are treated as words.
  function automatic logic [CNT_W-1:0] beat_count(input op_t op);
    case (op)
      LB, LBU, SB: beat_count = CNT_W'(1);
      LH, LHU, SH: beat_count = CNT_W'(2);
      default:     beat_count = CNT_W'(4);
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Sole owner of the byte-wide RAM/IO port: arbitrates store/load/fetch requests,
// serialises them into byte beats and assembles/extends read results.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] IO_BASE = IO_BASE_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              roll_back,
  input  logic [BYTE_W-1:0] mem_din,
  output logic [BYTE_W-1:0] mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_inst,
  input  logic              lsb_load,
  input  logic [ADDR_W-1:0] load_address,
  input  logic [OP_W-1:0]   op_type_load,
  output logic              finish_load,
  output logic [DATA_W-1:0] data_load,
  input  logic              lsb_store,
  input  logic [ADDR_W-1:0] store_address,
  input  logic [DATA_W-1:0] data_store,
  input  logic [OP_W-1:0]   op_type_store,
  output logic              finish_store
);

  state_e            state_q, state_d;
  state_e            kind_q, kind_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, n_q, n_d, nxt_cnt_c;
  logic              last_beat_c, store_blocked_c;
  logic [ADDR_W-1:0] addr_q, addr_d, mem_a_q, mem_a_d;
  op_t               op_q, op_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rbuf_q, rbuf_d, ext_c;
  logic [BYTE_W-1:0] mem_dout_q, mem_dout_d;
  logic              mem_wr_q, mem_wr_d;
  logic              if_done_q, if_done_d, finish_load_q, finish_load_d;
  logic              finish_store_q, finish_store_d;
  logic [DATA_W-1:0] if_inst_q, if_inst_d, data_load_q, data_load_d;

  assign nxt_cnt_c       = cnt_q + CNT_W'(1);
  assign last_beat_c     = (nxt_cnt_c == n_q);
  // An IO store waiting on a full UART holds the port and everything below it.
  assign store_blocked_c = lsb_store && (store_address >= IO_BASE) && io_buffer_full;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
    end else if (rdy_in) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!roll_back) begin
          if (lsb_store) begin
            if (!store_blocked_c) state_d = ST_STORE;
          end else if (lsb_load) begin
            state_d = ST_LOAD;
          end else if (if_req) begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_STORE: begin
        if (last_beat_c) state_d = ST_DONE;
      end
      ST_LOAD, ST_FETCH: begin
        if (roll_back)        state_d = ST_IDLE;
        else if (last_beat_c) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Beat sequencing, read assembly and done pulses.
  always_comb begin
    kind_d         = kind_q;
    cnt_d          = cnt_q;
    n_d            = n_q;
    addr_d         = addr_q;
    op_d           = op_q;
    wdata_d        = wdata_q;
    rbuf_d         = rbuf_q;
    mem_a_d        = mem_a_q;
    mem_dout_d     = mem_dout_q;
    mem_wr_d       = mem_wr_q;
    if_inst_d      = if_inst_q;
    data_load_d    = data_load_q;
    if_done_d      = FALSE;
    finish_load_d  = FALSE;
    finish_store_d = FALSE;
    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        rbuf_d = '0;
        kind_d = state_d;
        if (state_d == ST_STORE) begin
          addr_d     = store_address;
          n_d        = beat_count(op_type_store);
          wdata_d    = data_store;
          mem_a_d    = store_address;
          mem_dout_d = data_store[BYTE_W-1:0];
          mem_wr_d   = TRUE;
        end else if (state_d == ST_LOAD) begin
          addr_d  = load_address;
          op_d    = op_type_load;
          n_d     = beat_count(op_type_load);
          mem_a_d = load_address;
        end else if (state_d == ST_FETCH) begin
          addr_d  = if_addr;
          n_d     = CNT_W'(4);
          mem_a_d = if_addr;
        end
      end
      ST_STORE: begin
        if (last_beat_c) begin
          mem_wr_d       = FALSE;
          finish_store_d = TRUE;
        end else begin
          cnt_d      = nxt_cnt_c;
          mem_a_d    = addr_q + ADDR_W'(nxt_cnt_c);
          mem_dout_d = BYTE_W'(wdata_q >> {nxt_cnt_c[1:0], 3'b000});
        end
      end
      ST_LOAD, ST_FETCH: begin
        if (!roll_back) begin
          rbuf_d  = rbuf_q | (DATA_W'(mem_din) << {cnt_q[1:0], 3'b000});
          cnt_d   = nxt_cnt_c;
          mem_a_d = addr_q + ADDR_W'(nxt_cnt_c);
        end
      end
      ST_DONE: begin
        if (kind_q == ST_LOAD) begin
          finish_load_d = TRUE;
          data_load_d   = ext_c;
        end else if (kind_q == ST_FETCH) begin
          if_done_d = TRUE;
          if_inst_d = rbuf_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ext_c = rbuf_q;
    case (op_q)
      LB:      ext_c = {{24{rbuf_q[7]}}, rbuf_q[7:0]};
      LH:      ext_c = {{16{rbuf_q[15]}}, rbuf_q[15:0]};
      LBU:     ext_c = {24'h0, rbuf_q[7:0]};
      LHU:     ext_c = {16'h0, rbuf_q[15:0]};
      default: ext_c = rbuf_q;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      kind_q         <= ST_IDLE;
      cnt_q          <= '0;
      n_q            <= '0;
      addr_q         <= '0;
      op_q           <= '0;
      wdata_q        <= '0;
      rbuf_q         <= '0;
      mem_a_q        <= '0;
      mem_dout_q     <= '0;
      mem_wr_q       <= 1'b0;
      if_done_q      <= 1'b0;
      if_inst_q      <= '0;
      finish_load_q  <= 1'b0;
      data_load_q    <= '0;
      finish_store_q <= 1'b0;
    end else if (rdy_in) begin
      kind_q         <= kind_d;
      cnt_q          <= cnt_d;
      n_q            <= n_d;
      addr_q         <= addr_d;
      op_q           <= op_d;
      wdata_q        <= wdata_d;
      rbuf_q         <= rbuf_d;
      mem_a_q        <= mem_a_d;
      mem_dout_q     <= mem_dout_d;
      mem_wr_q       <= mem_wr_d;
      if_done_q      <= if_done_d;
      if_inst_q      <= if_inst_d;
      finish_load_q  <= finish_load_d;
      data_load_q    <= data_load_d;
      finish_store_q <= finish_store_d;
    end
  end

  assign mem_a        = mem_a_q;
  assign mem_dout     = mem_dout_q;
  assign mem_wr       = mem_wr_q & rdy_in;
  assign if_done      = if_done_q;
  assign if_inst      = if_inst_q;
  assign finish_load  = finish_load_q;
  assign data_load    = data_load_q;
  assign finish_store = finish_store_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte RAM model, done-pulse scoreboard and latency checks.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam logic [31:0] IO_BASE = 32'h0003_0000;
  localparam int K_ST = 0;
  localparam int K_LD = 1;
  localparam int K_IF = 2;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, roll_back, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_inst;
  logic        lsb_load, finish_load;
  logic [31:0] load_address, data_load;
  logic [5:0]  op_type_load, op_type_store;
  logic        lsb_store, finish_store;
  logic [31:0] store_address, data_store;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } sb_t;

  sb_t         exp_q[$];
  logic [39:0] wlog[$];
  logic [7:0]  ram [0:1023];
  int checks = 0, failures = 0;
  int n_fs = 0, n_fl = 0, n_if = 0, io_cnt = 0;
  logic [7:0] io_byte = 8'h00;

  assign mem_din = ram[mem_a[9:0]];

  mem_ctrl #(.IO_BASE(IO_BASE)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_inst(if_inst),
    .lsb_load(lsb_load), .load_address(load_address), .op_type_load(op_type_load),
    .finish_load(finish_load), .data_load(data_load),
    .lsb_store(lsb_store), .store_address(store_address), .data_store(data_store),
    .op_type_store(op_type_store), .finish_store(finish_store)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input int kind, input logic [31:0] data);
    sb_t e;
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("FAIL sb_unexpected observed=kind%0d/%0h expected=no_done", kind, data);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("sb_kind", 64'(kind), 64'(e.kind));
      chk("sb_data", 64'(data), 64'(e.data));
    end
  endtask

  task automatic push_exp(input int kind, input logic [31:0] data);
    sb_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // RAM/IO write side and done-pulse monitor, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk_in);
      if (!rst_in) begin
        if (mem_wr) begin
          wlog.push_back({mem_a, mem_dout});
          if (mem_a < 32'd1024) ram[mem_a[9:0]] = mem_dout;
          else begin
            io_cnt++;
            io_byte = mem_dout;
          end
        end
        if (finish_store) begin n_fs++; sb_pop(K_ST, 32'h0); end
        if (finish_load)  begin n_fl++; sb_pop(K_LD, data_load); end
        if (if_done)      begin n_if++; sb_pop(K_IF, if_inst); end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_pulse(input int which, input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if ((which == K_ST && finish_store) || (which == K_LD && finish_load) ||
          (which == K_IF && if_done)) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic do_load(input string tag, input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] exp, input int lat);
    int cyc;
    push_exp(K_LD, exp);
    lsb_load = 1'b1; load_address = addr; op_type_load = op;
    tick();
    wait_pulse(K_LD, 30, cyc);
    lsb_load = 1'b0;
    chk({tag, "_latency"}, 64'(cyc), 64'(lat));
    tick();
  endtask

  task automatic do_store(input string tag, input logic [5:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input int lat);
    int cyc;
    push_exp(K_ST, 32'h0);
    lsb_store = 1'b1; store_address = addr; data_store = data; op_type_store = op;
    tick();
    wait_pulse(K_ST, 30, cyc);
    lsb_store = 1'b0;
    chk({tag, "_latency"}, 64'(cyc), 64'(lat));
    repeat (2) tick();
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && (lsb_store || lsb_load || if_req); i++) begin
      tick();
      if (finish_store) lsb_store = 1'b0;
      if (finish_load)  lsb_load  = 1'b0;
      if (if_done)      if_req    = 1'b0;
    end
    chk({tag, "_drained"}, 64'({lsb_store, lsb_load, if_req}), 64'h0);
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, fs0, fl0, if0, io0, wr_hi;
    logic [31:0] d;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h13; ram[10'h101] = 8'h05; ram[10'h102] = 8'h00; ram[10'h103] = 8'h00;
    ram[10'h200] = 8'h80;
    ram[10'h210] = 8'h34; ram[10'h211] = 8'h92;
    ram[10'h220] = 8'h11; ram[10'h221] = 8'h22; ram[10'h222] = 8'h33; ram[10'h223] = 8'h44;
    ram[10'h3FF] = 8'hAA; ram[10'h000] = 8'hBB; ram[10'h001] = 8'hCC; ram[10'h002] = 8'hDD;
    ram[10'h302] = 8'h5A;
    rst_in = 1'b1; rdy_in = 1'b1; roll_back = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = '0; lsb_load = 1'b0; load_address = '0; op_type_load = '0;
    lsb_store = 1'b0; store_address = '0; data_store = '0; op_type_store = '0;

    repeat (3) tick();
    chk("reset_ctl", 64'({mem_a, mem_dout, mem_wr, if_done, finish_load, finish_store}), 64'h0);
    chk("reset_data", {if_inst, data_load}, 64'h0);
    rst_in = 1'b0;
    tick();
    chk("idle_ctl", 64'({mem_wr, if_done, finish_load, finish_store}), 64'h0);

    // Instruction fetch: little-endian word, never writes.
    wlog.delete();
    push_exp(K_IF, 32'h0000_0513);
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    wait_pulse(K_IF, 30, cyc);
    if_req = 1'b0;
    chk("fetch_latency", 64'(cyc), 64'd5);
    chk("fetch_no_write", 64'(wlog.size()), 64'd0);
    tick();

    do_load("lb",  LB,  32'h200, 32'hFFFF_FF80, 2);
    do_load("lbu", LBU, 32'h200, 32'h0000_0080, 2);
    do_load("lh",  LH,  32'h210, 32'hFFFF_9234, 3);
    do_load("lhu", LHU, 32'h210, 32'h0000_9234, 3);
    do_load("lw_wrap", LW, 32'hFFFF_FFFF, 32'hDDCC_BBAA, 5);

    // Half store: two beats, neighbouring byte untouched.
    wlog.delete();
    do_store("sh", SH, 32'h300, 32'h1234_ABCD, 2);
    chk("sh_beats", 64'(wlog.size()), 64'd2);
    if (wlog.size() == 2) begin
      chk("sh_beat0", 64'(wlog[0]), 64'({32'h300, 8'hCD}));
      chk("sh_beat1", 64'(wlog[1]), 64'({32'h301, 8'hAB}));
    end
    chk("sh_ram302", 64'(ram[10'h302]), 64'h5A);
    chk("sh_wr_low", 64'(mem_wr), 64'h0);

    // All three requesters at once: store, then load, then fetch.
    fs0 = n_fs; fl0 = n_fl; if0 = n_if;
    push_exp(K_ST, 32'h0);
    push_exp(K_LD, 32'h0000_0080);
    push_exp(K_IF, 32'h0000_0513);
    lsb_store = 1'b1; store_address = 32'h310; data_store = 32'h0000_0077; op_type_store = SB;
    lsb_load = 1'b1; load_address = 32'h200; op_type_load = LBU;
    if_req = 1'b1; if_addr = 32'h100;
    drain("simul", 60);
    chk("simul_counts", 64'({n_fs - fs0, n_fl - fl0, n_if - if0}), {32'h0, 32'h1, 32'h1, 32'h1} >> 32);
    chk("simul_ram", 64'(ram[10'h310]), 64'h77);
    chk("simul_sb_empty", 64'(exp_q.size()), 64'd0);

    // roll_back during the second beat of a word load aborts it silently.
    fl0 = n_fl;
    lsb_load = 1'b1; load_address = 32'h220; op_type_load = LW;
    tick();
    tick();
    roll_back = 1'b1; lsb_load = 1'b0;
    tick();
    roll_back = 1'b0;
    do_load("after_rb", LBU, 32'h200, 32'h0000_0080, 2);
    chk("rb_load_count", 64'(n_fl - fl0), 64'd1);

    // roll_back is ignored by a store; rdy_in low gates mem_wr and stretches it.
    wlog.delete();
    d = 32'hDEAD_BEEF;
    push_exp(K_ST, 32'h0);
    lsb_store = 1'b1; store_address = 32'h320; data_store = d; op_type_store = SW;
    tick();
    tick();
    roll_back = 1'b1;
    tick();
    roll_back = 1'b0; rdy_in = 1'b0;
    #1;
    chk("rdy_gates_wr", 64'(mem_wr), 64'h0);
    tick();
    rdy_in = 1'b1;
    wait_pulse(K_ST, 30, cyc);
    lsb_store = 1'b0;
    chk("sw_rb_latency", 64'(cyc), 64'd2);
    repeat (2) tick();
    chk("sw_beats", 64'(wlog.size()), 64'd4);
    for (int i = 0; i < 4 && i < wlog.size(); i++)
      chk("sw_beat", 64'(wlog[i]), 64'({32'h320 + 32'(i), 8'(d >> (8 * i))}));

    // rdy_in low for 3 cycles mid word load.
    push_exp(K_LD, 32'h4433_2211);
    lsb_load = 1'b1; load_address = 32'h220; op_type_load = LW;
    tick();
    tick();
    rdy_in = 1'b0;
    repeat (3) tick();
    rdy_in = 1'b1;
    wait_pulse(K_LD, 30, cyc);
    lsb_load = 1'b0;
    chk("lw_rdy_latency", 64'(cyc), 64'd4);
    tick();

    // IO store stalls on a full UART buffer and blocks the fetch behind it.
    io0 = io_cnt; if0 = n_if; wr_hi = 0;
    io_buffer_full = 1'b1;
    push_exp(K_ST, 32'h0);
    push_exp(K_IF, 32'h0000_0513);
    lsb_store = 1'b1; store_address = IO_BASE; data_store = 32'h0000_0041; op_type_store = SB;
    if_req = 1'b1; if_addr = 32'h100;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_wr) wr_hi++;
    end
    chk("io_stall_wr", 64'(wr_hi), 64'd0);
    chk("io_stall_fetch", 64'(n_if - if0), 64'd0);
    io_buffer_full = 1'b0;
    drain("io", 60);
    chk("io_writes", 64'(io_cnt - io0), 64'd1);
    chk("io_byte", 64'(io_byte), 64'h41);
    chk("io_fetch", 64'(n_if - if0), 64'd1);

    // Asynchronous reset mid-access clears outputs and drops the access.
    fl0 = n_fl;
    lsb_load = 1'b1; load_address = 32'h220; op_type_load = LW;
    tick();
    tick();
    #3;
    rst_in = 1'b1; lsb_load = 1'b0;
    #1;
    chk("async_rst_ctl", 64'({mem_a, mem_wr, finish_load, if_done}), 64'h0);
    chk("async_rst_data", {if_inst, data_load}, 64'h0);
    tick();
    rst_in = 1'b0;
    repeat (8) tick();
    chk("rst_no_done", 64'(n_fl - fl0), 64'd0);
    chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
